ysyx_23060072_multdiv_seq: RTL and testbench
============================================

Name: ysyx_23060072_multdiv_seq

Overview:
Parametrised iterative RV32M multiply/divide unit for the EX stage. It replaces the tied-off multdiv hold path with a real multi-cycle engine.
- Multiply is shift-add, retiring MUL_BITS bits per cycle; divide is restoring, 1 bit per cycle.
- Divide-by-zero and signed overflow take a fast path.
- Stalls EX through hold_flag_o; the result is consumed through the same wb_data path as ALU/CSR results.

Parameters:
XLEN, 32, operand/result width (16, 32 or 64)
MUL_BITS, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4 or 8)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
multdiv_en_i  input  1  EX instruction is M-extension
op_i  input  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8-15 invalid
operand_a_i  input  XLEN  rs1 value
operand_b_i  input  XLEN  rs2 value
accept_i  input  1  EX may advance this cycle (no stall from other sources)
flush_i  input  1  kill EX instruction (jump/trap)
result_o  output  XLEN  registered result, valid when valid_o
valid_o  output  1  result available (DONE state)
hold_flag_o  output  1  stall request to controller
busy_o  output  1  state is BUSY

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0, result_o 0, valid_o 0, busy_o 0. hold_flag_o is 0 because no enable is sampled in reset. Reset mid-operation abandons the operation immediately.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If multdiv_en_i and !flush_i, latch op, operand magnitudes and result-sign info.
  - Special case (divisor 0, DIV/REM of -2^(XLEN-1) by -1, or invalid op): go to DONE.
  - Otherwise go to BUSY with counter = XLEN/MUL_BITS (multiply) or XLEN (divide).
- BUSY: one step per cycle, counter decrements. When counter reaches 1, write the sign-corrected result into result_o and go to DONE.
- DONE: valid_o=1.
  - accept_i=1: go to IDLE.
  - accept_i=0: stay in DONE, holding result_o; the held instruction must not restart.
- hold_flag_o = !flush_i & ((IDLE & multdiv_en_i) | BUSY). It is 0 in DONE.
- Latency:
  - Normal: hold high for 1 + N cycles (N = 32 MUL, 32 DIV at XLEN=32, MUL_BITS=1; MUL N=8 at MUL_BITS=4). valid_o asserts the following cycle.
  - Special case: hold for 1 cycle; DONE next cycle.
- Arithmetic:
  - Full 2*XLEN-bit product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned interpretation respectively.
  - Signed ops operate on magnitudes, then negate when operand signs differ. For REM the sign follows the dividend.
- Special results:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = dividend.
  - Overflow: DIV = -2^(XLEN-1); REM = 0.
  - Invalid op: 0.
- flush_i: any state goes to IDLE next cycle. hold_flag_o is forced 0 in the flush cycle; no result is produced.
- multdiv_en_i is ignored outside IDLE.
- result_o changes only on entry to DONE or on reset.

Test Plan:
- MULH 0x80000000 × 0x80000000, accept_i=1 -> hold 33 cycles, then valid_o=1, result_o=0x40000000, back to IDLE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> result_o=0xFFFFFFFF; MUL 3×5 -> 0x0000000F; with MUL_BITS=4, hold 9 cycles.
- DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; each holds 33 cycles.
- DIVU 0x12345678/0 -> 0xFFFFFFFF and REM 0x12345678,0 -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. All with 1 hold cycle.
- flush_i in BUSY cycle 10 -> hold_flag_o 0 that cycle, IDLE next, valid_o never set. A following MUL 3×5 returns 15.
- accept_i=0 for 2 DONE cycles -> valid_o and result stay stable, no restart, hold_flag_o 0. Async rst_n pulse during BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_23060072_multdiv_seq.sv
// Iterative RV32M multiply/divide engine for the EX stage: shift-add multiply
// retiring MUL_BITS bits per cycle, restoring divide retiring 1 bit per cycle.
module ysyx_23060072_multdiv_seq #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            multdiv_en_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            accept_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            hold_flag_o,
    output logic            busy_o
);
    localparam int              CW        = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [CW-1:0]   MUL_STEPS = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0]   DIV_STEPS = CW'(XLEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t                   state_r, state_nxt_s;
    logic [CW-1:0]            cnt_r, cnt_nxt_s;
    logic [3:0]               op_r;
    logic                     neg_r;
    logic [XLEN-1:0]          b_mag_r;
    logic [2*XLEN-1:0]        acc_r;
    logic [XLEN-1:0]          result_r, result_nxt_s;
    logic                     valid_r, busy_r;
    logic                     load_s, step_s;

    logic                     a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_in_s;
    logic [XLEN-1:0]          a_mag_s, b_mag_s, special_res_s, final_s, div_half_s;
    logic                     invalid_s, div_zero_s, ovf_s, special_s;
    logic [XLEN+MUL_BITS-1:0] partial_s, sum_s;
    logic [XLEN:0]            trial_s;
    logic [XLEN-1:0]          rem_new_s;
    logic [2*XLEN-1:0]        mul_nxt_s, div_nxt_s, mul_fin_s;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Operand signedness per opcode: MUL/MULH/DIV/REM signed x signed, MULHSU signed x unsigned.
    always_comb begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        case (op_i)
            4'd0, 4'd1, 4'd4, 4'd6: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
            4'd2:                   begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
            default:                begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
        endcase
    end

    assign a_neg_s    = a_sgn_s & operand_a_i[XLEN-1];
    assign b_neg_s    = b_sgn_s & operand_b_i[XLEN-1];
    assign a_mag_s    = abs_val(operand_a_i, a_neg_s);
    assign b_mag_s    = abs_val(operand_b_i, b_neg_s);
    // Remainder takes the dividend's sign; everything else the sign product.
    assign neg_in_s   = (op_i[2] & op_i[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
    assign invalid_s  = op_i[3];
    assign div_zero_s = ~op_i[3] & op_i[2] & (operand_b_i == {XLEN{1'b0}});
    assign ovf_s      = ~op_i[3] & op_i[2] & ~op_i[0] &
                        (operand_a_i == MIN_NEG) & (operand_b_i == ALL_ONES);
    assign special_s  = invalid_s | div_zero_s | ovf_s;

    // Fast-path results that bypass the iterative engine.
    always_comb begin
        if (invalid_s) begin
            special_res_s = {XLEN{1'b0}};
        end else if (div_zero_s) begin
            special_res_s = op_i[1] ? operand_a_i : ALL_ONES;
        end else if (ovf_s) begin
            special_res_s = op_i[1] ? {XLEN{1'b0}} : MIN_NEG;
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

    // One iteration of each engine; acc_r holds {high/remainder, low/quotient}.
    always_comb begin
        partial_s = {{MUL_BITS{1'b0}}, b_mag_r} * {{XLEN{1'b0}}, acc_r[MUL_BITS-1:0]};
        sum_s     = {{MUL_BITS{1'b0}}, acc_r[2*XLEN-1:XLEN]} + partial_s;
        mul_nxt_s = {sum_s, acc_r[XLEN-1:MUL_BITS]};
        trial_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]} - {1'b0, b_mag_r};
        rem_new_s = trial_s[XLEN] ? acc_r[2*XLEN-2:XLEN-1] : trial_s[XLEN-1:0];
        div_nxt_s = {rem_new_s, acc_r[XLEN-2:0], ~trial_s[XLEN]};
        mul_fin_s = neg_r ? -mul_nxt_s : mul_nxt_s;
        div_half_s = op_r[1] ? div_nxt_s[2*XLEN-1:XLEN] : div_nxt_s[XLEN-1:0];
        if (op_r[2]) begin
            final_s = neg_r ? -div_half_s : div_half_s;
        end else if (op_r[1:0] != 2'b00) begin
            final_s = mul_fin_s[2*XLEN-1:XLEN];
        end else begin
            final_s = mul_fin_s[XLEN-1:0];
        end
    end

    // Next-state logic for IDLE -> BUSY/DONE -> IDLE sequencing.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        result_nxt_s = result_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (multdiv_en_i && !flush_i) begin
                    load_s = 1'b1;
                    if (special_s) begin
                        state_nxt_s  = S_DONE;
                        result_nxt_s = special_res_s;
                        cnt_nxt_s    = {CW{1'b0}};
                    end else begin
                        state_nxt_s = S_BUSY;
                        cnt_nxt_s   = op_i[2] ? DIV_STEPS : MUL_STEPS;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    step_s    = 1'b1;
                    cnt_nxt_s = cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_nxt_s  = S_DONE;
                        result_nxt_s = final_s;
                    end else begin
                        state_nxt_s = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                if (flush_i || accept_i) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CW{1'b0}};
            result_r <= {XLEN{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            result_r <= result_nxt_s;
            valid_r  <= (state_nxt_s == S_DONE);
            busy_r   <= (state_nxt_s == S_BUSY);
        end
    end

    // Operand capture and iterative accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 4'd0;
            neg_r   <= 1'b0;
            b_mag_r <= {XLEN{1'b0}};
            acc_r   <= {(2*XLEN){1'b0}};
        end else if (load_s) begin
            op_r    <= op_i;
            neg_r   <= neg_in_s;
            b_mag_r <= b_mag_s;
            acc_r   <= {{XLEN{1'b0}}, a_mag_s};
        end else if (step_s) begin
            acc_r   <= op_r[2] ? div_nxt_s : mul_nxt_s;
        end else begin
            acc_r   <= acc_r;
        end
    end

    assign result_o    = result_r;
    assign valid_o     = valid_r;
    assign busy_o      = busy_r;
    assign hold_flag_o = !flush_i && (((state_r == S_IDLE) && multdiv_en_i) || (state_r == S_BUSY));

endmodule

// File: tb/tb_ysyx_23060072_multdiv_seq.sv
// Randomized bench for the multdiv engine: two instances (MUL_BITS 1 and 4)
// checked against a plain 64-bit arithmetic reference model.
module tb_ysyx_23060072_multdiv_seq;
    localparam logic [31:0] MIN  = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, en, accept, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] res1, res4;
    logic        valid1, valid4, hold1, hold4, busy1, busy4;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ysyx_23060072_multdiv_seq #(.XLEN(32), .MUL_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .multdiv_en_i(en), .op_i(op),
        .operand_a_i(a), .operand_b_i(b), .accept_i(accept), .flush_i(flush),
        .result_o(res1), .valid_o(valid1), .hold_flag_o(hold1), .busy_o(busy1));

    ysyx_23060072_multdiv_seq #(.XLEN(32), .MUL_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .multdiv_en_i(en), .op_i(op),
        .operand_a_i(a), .operand_b_i(b), .accept_i(accept), .flush_i(flush),
        .result_o(res4), .valid_o(valid4), .hold_flag_o(hold4), .busy_o(busy4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy, q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (o)
            4'd0: begin p = sx * sy; return p[31:0]; end
            4'd1: begin p = sx * sy; return p[63:32]; end
            4'd2: begin p = sx * uy; return p[63:32]; end
            4'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            4'd4: begin if (y == 32'd0) return ONES; q = sx / sy; p = q; return p[31:0]; end
            4'd5: begin if (y == 32'd0) return ONES; q = ux / uy; p = q; return p[31:0]; end
            4'd6: begin if (y == 32'd0) return x; q = sx % sy; p = q; return p[31:0]; end
            4'd7: begin if (y == 32'd0) return x; q = ux % uy; p = q; return p[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_hold(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int mb);
        if (o >= 4'd8) return 1;
        if (o >= 4'd4) begin
            if (y == 32'd0) return 1;
            if ((o == 4'd4 || o == 4'd6) && x == MIN && y == ONES) return 1;
            return 33;
        end
        return 1 + 32 / mb;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return MIN;
            2:       return ONES;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction (enable for one cycle), track both engines to completion.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int          h1, h4, n;
        bit          d1, d4;
        logic [31:0] r1, r4;
        h1 = 0; h4 = 0; n = 0; d1 = 1'b0; d4 = 1'b0; r1 = 32'd0; r4 = 32'd0;
        @(posedge clk); #1;
        en = 1'b1; op = o; a = x; b = y;
        while (!(d1 && d4) && n < 100) begin
            @(negedge clk);
            if (hold1 && !d1) h1++;
            if (hold4 && !d4) h4++;
            if (valid1 && !d1) begin d1 = 1'b1; r1 = res1; end
            if (valid4 && !d4) begin d4 = 1'b1; r4 = res4; end
            @(posedge clk); #1;
            en = 1'b0;
            n++;
        end
        chk("done_mb1", 64'(d1), 64'd1);
        chk("done_mb4", 64'(d4), 64'd1);
        chk($sformatf("res_mb1 op%0d %h,%h", o, x, y), 64'(r1), 64'(model(o, x, y)));
        chk($sformatf("res_mb4 op%0d %h,%h", o, x, y), 64'(r4), 64'(model(o, x, y)));
        chk($sformatf("hold_mb1 op%0d", o), 64'(h1), 64'(exp_hold(o, x, y, 1)));
        chk($sformatf("hold_mb4 op%0d", o), 64'(h4), 64'(exp_hold(o, x, y, 4)));
        chk("idle_after", 64'({valid1, busy1, valid4, busy4}), 64'd0);
    endtask

    initial begin
        int          vcnt;
        int          n;
        logic [31:0] held;
        rst_n = 1'b0; en = 1'b0; accept = 1'b1; flush = 1'b0;
        op = 4'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res",  64'(res1), 64'd0);
        chk("reset_flags", 64'({valid1, busy1, hold1, valid4, busy4, hold4}), 64'd0);
        rst_n = 1'b1;

        run_op(4'd1, MIN, MIN);
        run_op(4'd2, ONES, ONES);
        run_op(4'd0, 32'd3, 32'd5);
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(4'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(4'd5, 32'd100, 32'd7);
        run_op(4'd7, 32'd100, 32'd7);
        run_op(4'd5, 32'h1234_5678, 32'd0);
        run_op(4'd6, 32'h1234_5678, 32'd0);
        run_op(4'd4, MIN, ONES);
        run_op(4'd6, MIN, ONES);
        run_op(4'd9, 32'd7, 32'd3);

        // Flush on the tenth busy cycle of a divide.
        @(posedge clk); #1;
        en = 1'b1; op = 4'd4; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_busy", 64'(busy1), 64'd1);
        chk("flush_hold", 64'({hold1, hold4}), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", 64'({busy1, valid1, hold1, busy4, valid4, hold4}), 64'd0);
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid1 || valid4) vcnt++;
        end
        chk("flush_no_valid", 64'(vcnt), 64'd0);
        run_op(4'd0, 32'd3, 32'd5);

        // Stall in DONE: result held, no restart, no hold.
        accept = 1'b0;
        @(posedge clk); #1;
        en = 1'b1; op = 4'd0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        en = 1'b0;
        n = 0;
        while (!(valid1 && valid4) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reach_done", 64'({valid1, valid4}), 64'h3);
        held = res1;
        chk("stall_res", 64'(held), 64'd15);
        repeat (2) begin
            @(negedge clk);
            chk("stall_valid", 64'({valid1, valid4}), 64'h3);
            chk("stall_res_held", 64'(res1), 64'(held));
            chk("stall_nohold", 64'({hold1, busy1, hold4, busy4}), 64'd0);
        end
        accept = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", 64'({valid1, busy1, valid4, busy4}), 64'd0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] ro;
            ro = 4'($urandom_range(0, 9));
            run_op(ro, pick(), pick());
        end

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        en = 1'b1; op = 4'd3; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_res", 64'({res1, res4}), 64'd0);
        chk("arst_flags", 64'({valid1, busy1, hold1, valid4, busy4, hold4}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(4'd0, 32'd3, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
